mac_dot_accumulator: RTL and testbench
======================================

Name: mac_dot_accumulator

Overview:
- Sequential stage directly downstream of the team's 4x4 combinational array multiplier.
- Takes a stream of 8-bit unsigned products over a valid/ready handshake and sums each packet (one dot product) into a wide accumulator.
- Presents the final sum, term count and overflow flag on a valid/ready output.
- Gives the purely combinational multiplier a registered, flow-controlled sink usable for vector dot products.

Parameters:
- ACC_W, 16, accumulator and result width in bits; must be >= 8.
- MAX_LEN, 16, maximum terms per packet; a packet auto-terminates on its MAX_LEN-th term.
- CNT_W, $clog2(MAX_LEN+1), width of the term counter and the out_count port.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous abort; discards any partial or held packet.
- in_valid  input  1  in_product/in_last are valid.
- in_ready  output  1  block can accept a term this cycle.
- in_product  input  8  unsigned product from the multiplier.
- in_last  input  1  marks the final term of a packet.
- out_valid  output  1  result fields are valid and held.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  ACC_W  packet sum, modulo 2^ACC_W.
- out_count  output  CNT_W  number of terms in the packet.
- out_ovf  output  1  sum exceeded 2^ACC_W-1 at some point in the packet.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=ACC; accumulator, counter and ovf are 0.
  - out_valid=0, out_sum=0, out_count=0, out_ovf=0.
  - in_ready=1 from the first cycle after rst_n deasserts.
- Two states: ACC and HOLD.
- ACC:
  - in_ready=1, out_valid=0.
  - A beat is accepted when in_valid & in_ready.
  - On accept: acc <= acc + zero-extended in_product, truncated to ACC_W. The carry out of bit ACC_W-1 ORs into sticky ovf. cnt <= cnt+1.
  - If in_last=1, or the accepted term is number MAX_LEN (cnt==MAX_LEN-1 before increment): on the same edge latch out_sum, out_count and out_ovf from the post-add values, then go to HOLD.
  - No accept means all state is held.
- HOLD:
  - out_valid=1, in_ready=0.
  - Outputs are stable while out_valid & !out_ready.
  - On out_ready: acc, cnt and ovf clear to 0, state goes to ACC, out_valid drops the next cycle.
  - out_sum, out_count and out_ovf keep their last value after the handshake; they are don't-care when out_valid=0.
- Latency: out_valid rises on the clock edge that accepts the last term. Result is visible 1 cycle after the last beat.
- Throughput:
  - One term per cycle within a packet.
  - Minimum one HOLD cycle between packets; in_ready is low for that cycle.
  - Back-to-back: a packet of N terms costs N+1 cycles when out_ready is held high.
- Boundary conditions:
  - Single-term packet (in_last on the first beat): out_count=1, out_sum=in_product.
  - in_last on term MAX_LEN is treated the same as auto-terminate; there is no double end.
  - in_valid while in HOLD is ignored; the upstream must hold its data (standard valid/ready).
  - clr takes priority over everything. Next edge: state=ACC, acc/cnt/ovf=0, out_valid=0. A term offered in the same cycle as clr is dropped and not accumulated.
  - rst_n asserted mid-packet or during HOLD: immediate return to the reset values; the partial packet is lost.
  - ovf is per-packet and clears together with acc.

Decomposition:
- Shared package:
  - state enum (ACC, HOLD).
  - PROD_W=8 constant, shared with the multiplier's output width.
  - Default ACC_W/MAX_LEN constants.
- Sub-module `acc_add_ovf`: ACC_W adder that takes acc and the zero-extended product and returns sum and carry out. It is purely combinational.
- FSM, counter and output registers stay in the top.

Test Plan:
- Reset then packet of products 225,225,225,225 with in_last on the 4th beat, out_ready=1 -> out_valid 1 cycle after the 4th beat; out_sum=900, out_count=4, out_ovf=0; in_ready low for exactly 1 cycle.
- 16 beats of 255 with no in_last (MAX_LEN=16) -> auto-terminate on beat 16; out_sum=4080, out_count=16.
- ACC_W=12 instance, products 255 x17 with in_last on the 17th and MAX_LEN=32 -> out_sum=4335 mod 4096=239, out_ovf=1. The next packet [1] -> out_sum=1, out_ovf=0.
- Output backpressure: out_ready=0 for 5 cycles after result 57, with in_valid held high carrying 9 -> outputs stable at 57 and in_ready=0 throughout. On out_ready=1 the pending 9 is accepted next and the next packet starts from 0.
- clr asserted on the 3rd beat of [10,20,30,40(last)] -> 30 not counted. Re-sent packet [5(last)] -> out_sum=5, out_count=1.
- rst_n pulsed low asynchronously mid-cycle during HOLD -> out_valid falls immediately, all outputs 0, in_ready=1 after release.

Source files
------------

// File: rtl/mac_dot_accumulator_pkg.sv
// Shared types and constants for the dot-product accumulator stage.
// No logic; constants only.
// Backpressure: n/a.
package mac_dot_accumulator_pkg;

  // Width of the upstream 4x4 multiplier's product.
  localparam int PROD_W      = 8;
  localparam int DEF_ACC_W   = 16;
  localparam int DEF_MAX_LEN = 16;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/mac_dot_accumulator_if.sv
// Term stream in, result stream out, both valid/ready.
// No logic; the signals are bundled here.
// Backpressure: in_ready / out_ready as in a standard valid/ready stream.
interface mac_dot_accumulator_if #(
  parameter int ACC_W = mac_dot_accumulator_pkg::DEF_ACC_W,
  parameter int CNT_W = 5
);
  import mac_dot_accumulator_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_ovf;

  modport master (
    output in_valid, in_product, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_product, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

endinterface

// File: rtl/mac_dot_accumulator_add.sv
// Accumulator adder: acc plus zero-extended product, with carry out.
// Latency: combinational.
// Backpressure: none.
module acc_add_ovf
  import mac_dot_accumulator_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] product,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  // One extra bit catches the carry out of the top accumulator bit.
  assign {carry, sum} = {1'b0, acc} + (ACC_W+1)'(product);

endmodule

// File: rtl/mac_dot_accumulator.sv
// Sums a packet of unsigned products into a wide accumulator; reports sum, count, overflow.
// Latency: result valid on the edge that accepts the last term (1 cycle after the last beat).
// Backpressure: in_ready low while a result is held; result held until out_ready.
module mac_dot_accumulator
  import mac_dot_accumulator_pkg::*;
#(
  parameter int ACC_W   = DEF_ACC_W,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  mac_dot_accumulator_if.slave  bus
);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic [ACC_W-1:0] sum_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;

  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic             accept;
  logic             end_term;
  logic [CNT_W-1:0] cnt_next;
  logic             ovf_next;

  acc_add_ovf #(.ACC_W(ACC_W)) u_add (
    .acc     (acc),
    .product (bus.in_product),
    .sum     (add_sum),
    .carry   (add_carry)
  );

  // A term offered together with clr is dropped, so clr gates acceptance.
  assign accept   = (state == ACC) && bus.in_valid && !clr;
  // The MAX_LEN-th term closes the packet whether or not in_last is set.
  assign end_term = bus.in_last || (cnt == CNT_W'(MAX_LEN - 1));
  assign cnt_next = cnt + CNT_W'(1);
  assign ovf_next = ovf | add_carry;

  assign bus.in_ready  = (state == ACC);
  assign bus.out_valid = (state == HOLD);
  assign bus.out_sum   = sum_q;
  assign bus.out_count = count_q;
  assign bus.out_ovf   = ovf_q;

  // Packet FSM: accumulate in ACC, present the latched result in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ACC;
      acc     <= '0;
      cnt     <= '0;
      ovf     <= 1'b0;
      sum_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else if (clr) begin
      state <= ACC;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            acc <= add_sum;
            cnt <= cnt_next;
            ovf <= ovf_next;
            if (end_term) begin
              sum_q   <= add_sum;
              count_q <= cnt_next;
              ovf_q   <= ovf_next;
              state   <= HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            state <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_dot_accumulator.sv
// Scoreboard bench for two accumulator instances (16-bit/16-term and 12-bit/32-term).
// Stimulus pushes expected results; per-instance monitors compare on every held result.
// Backpressure is exercised by holding out_ready low with a pending term.
module tb_mac_dot_accumulator;

  typedef struct {
    logic [15:0] sum;
    int          count;
    bit          ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr0 = 1'b0;
  logic clr1 = 1'b0;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  mac_dot_accumulator_if #(.ACC_W(16), .CNT_W(5)) b0 ();
  mac_dot_accumulator_if #(.ACC_W(12), .CNT_W(6)) b1 ();

  mac_dot_accumulator #(.ACC_W(16), .MAX_LEN(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr0), .bus(b0.slave)
  );

  mac_dot_accumulator #(.ACC_W(12), .MAX_LEN(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr1), .bus(b1.slave)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor for instance 0: compare every cycle a result is presented.
  always @(negedge clk) begin
    if (rst_n && b0.out_valid === 1'b1) begin
      if (q0.size() == 0) begin
        check("dut0_unexpected_result", 1, 0);
      end else begin
        check("dut0_sum", int'(b0.out_sum), int'(q0[0].sum));
        check("dut0_count", int'(b0.out_count), q0[0].count);
        check("dut0_ovf", int'(b0.out_ovf), int'(q0[0].ovf));
        if (b0.out_ready) void'(q0.pop_front());
      end
    end
  end

  // Monitor for instance 1.
  always @(negedge clk) begin
    if (rst_n && b1.out_valid === 1'b1) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_result", 1, 0);
      end else begin
        check("dut1_sum", int'(b1.out_sum), int'(q1[0].sum));
        check("dut1_count", int'(b1.out_count), q1[0].count);
        check("dut1_ovf", int'(b1.out_ovf), int'(q1[0].ovf));
        if (b1.out_ready) void'(q1.pop_front());
      end
    end
  end

  // Offer one term; called at a negedge, returns at the negedge after acceptance.
  task automatic beat(input int which, input logic [7:0] p, input bit last);
    int n = 0;
    bit rdy;
    if (which == 0) begin
      b0.in_valid = 1'b1; b0.in_product = p; b0.in_last = last;
    end else begin
      b1.in_valid = 1'b1; b1.in_product = p; b1.in_last = last;
    end
    rdy = (which == 0) ? b0.in_ready : b1.in_ready;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
      rdy = (which == 0) ? b0.in_ready : b1.in_ready;
    end
    if (!rdy) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    @(negedge clk);
    if (which == 0) b0.in_valid = 1'b0;
    else            b1.in_valid = 1'b0;
  endtask

  task automatic push(input int which, input int s, input int c, input bit o);
    exp_t e;
    e.sum = 16'(s); e.count = c; e.ovf = o;
    if (which == 0) q0.push_back(e);
    else            q1.push_back(e);
  endtask

  initial begin
    b0.in_valid = 0; b0.in_product = 0; b0.in_last = 0; b0.out_ready = 1;
    b1.in_valid = 0; b1.in_product = 0; b1.in_last = 0; b1.out_ready = 1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state.
    check("rst_out_valid", int'(b0.out_valid), 0);
    check("rst_out_sum", int'(b0.out_sum), 0);
    check("rst_out_count", int'(b0.out_count), 0);
    check("rst_out_ovf", int'(b0.out_ovf), 0);
    check("rst_in_ready", int'(b0.in_ready), 1);

    // 4 x 225 with in_last on the 4th term.
    push(0, 900, 4, 0);
    for (int i = 0; i < 4; i++) beat(0, 8'd225, i == 3);
    check("p1_out_valid_after_last", int'(b0.out_valid), 1);
    check("p1_in_ready_hold", int'(b0.in_ready), 0);
    @(negedge clk);
    check("p1_in_ready_back", int'(b0.in_ready), 1);
    check("p1_out_valid_drop", int'(b0.out_valid), 0);

    // 16 x 255, no in_last: auto-terminates on the 16th term.
    push(0, 4080, 16, 0);
    for (int i = 0; i < 16; i++) beat(0, 8'd255, 1'b0);
    check("p2_autoterm_valid", int'(b0.out_valid), 1);
    @(negedge clk);

    // 12-bit instance: 17 x 255 wraps to 239 with overflow, then [1] starts clean.
    push(1, 239, 17, 1);
    for (int i = 0; i < 17; i++) beat(1, 8'd255, i == 16);
    push(1, 1, 1, 0);
    beat(1, 8'd1, 1'b1);
    @(negedge clk);

    // Backpressure: result 57 held for 5 cycles while 9 waits upstream.
    b0.out_ready = 1'b0;
    push(0, 57, 2, 0);
    beat(0, 8'd50, 1'b0);
    beat(0, 8'd7, 1'b1);
    b0.in_valid = 1'b1; b0.in_product = 8'd9; b0.in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready_low", int'(b0.in_ready), 0);
      @(negedge clk);
    end
    b0.out_ready = 1'b1;
    push(0, 9, 1, 0);
    beat(0, 8'd9, 1'b1);
    @(negedge clk);

    // clr on the 3rd term drops 10+20+30; [5] afterwards starts from zero.
    beat(0, 8'd10, 1'b0);
    beat(0, 8'd20, 1'b0);
    clr0 = 1'b1;
    b0.in_valid = 1'b1; b0.in_product = 8'd30; b0.in_last = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clr0 = 1'b0;
    b0.in_valid = 1'b0;
    check("clr_no_result", int'(b0.out_valid), 0);
    push(0, 5, 1, 0);
    beat(0, 8'd5, 1'b1);
    @(negedge clk);

    // Asynchronous reset during HOLD.
    b0.out_ready = 1'b0;
    push(0, 7, 1, 0);
    beat(0, 8'd7, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    q0.delete();
    #1;
    check("arst_out_valid", int'(b0.out_valid), 0);
    check("arst_out_sum", int'(b0.out_sum), 0);
    check("arst_out_count", int'(b0.out_count), 0);
    check("arst_out_ovf", int'(b0.out_ovf), 0);
    b0.out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_in_ready", int'(b0.in_ready), 1);
    push(0, 3, 1, 0);
    beat(0, 8'd3, 1'b1);
    repeat (3) @(negedge clk);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
